// File: rtl/dcache_miss_handler.sv
// dcache_miss_handler: commit-side miss engine (victim writeback, line refill, tag rewrite).
// Optional `DCACHE_MISS_PERF_CNT_EN adds saturating perf_miss_cnt / perf_wb_cnt outputs.
module dcache_miss_handler #(
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 20,
    parameter int WAY_NUM        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_paddr,
    input  logic [WAY_NUM-1:0]   req_way,
    input  logic                 req_dirty,
    input  logic [TAG_W-1:0]     req_victim_tag,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic [31:0]          sram_addr,
    output logic [WAY_NUM-1:0]   sram_way,
    output logic [3:0]           sram_data_we,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata,
    output logic                 sram_tag_we,
    output logic [TAG_W+1:0]     sram_tag_data,
    output logic                 bus_rd_valid,
    input  logic                 bus_rd_ready,
    output logic [31:0]          bus_rd_addr,
    input  logic                 bus_r_valid,
    input  logic [31:0]          bus_r_data,
    input  logic                 bus_r_last,
    output logic                 bus_wr_valid,
    input  logic                 bus_wr_ready,
    output logic [31:0]          bus_wr_addr,
    output logic                 bus_w_valid,
    input  logic                 bus_w_ready,
    output logic [31:0]          bus_w_data,
    output logic                 bus_w_last,
    input  logic                 bus_b_valid
`ifdef DCACHE_MISS_PERF_CNT_EN
    ,
    output logic [31:0]          perf_miss_cnt,
    output logic [31:0]          perf_wb_cnt
`endif
);
    localparam int LW  = $clog2(WORDS_PER_LINE);
    localparam int OFF = LW + 2;
    localparam logic [LW:0] CNT_END = (LW+1)'(WORDS_PER_LINE);

    typedef enum logic [3:0] {IDLE, WB_RD, WB_AW, WB_W, WB_B, RF_AR, RF_R, TAG_WR, DONE} state_t;

    state_t              r_state, w_next;
    logic [31:2]         r_paddr;
    logic [WAY_NUM-1:0]  r_way;
    logic [TAG_W-1:0]    r_vtag;
    logic [LW:0]         r_cnt;
    logic [LW:0]         w_cnt_m1;
    logic [LW-1:0]       r_beat;
    logic [31:0]         r_buf [WORDS_PER_LINE];
    logic                r_drop;
    logic                w_accept;
    logic [31-OFF:0]     w_victim;
    logic                w_unused;

    assign w_unused = ^req_paddr[1:0];
    assign w_accept = (r_state == IDLE) && req_valid && !flush_i;
    assign w_victim = {r_vtag, r_paddr[31-TAG_W:OFF]};
    assign w_cnt_m1 = r_cnt - 1'b1;

    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        sram_addr     = '0;
        sram_way      = '0;
        sram_data_we  = '0;
        sram_wdata    = '0;
        sram_tag_we   = 1'b0;
        sram_tag_data = '0;
        bus_rd_valid  = 1'b0;
        bus_rd_addr   = '0;
        bus_wr_valid  = 1'b0;
        bus_wr_addr   = '0;
        bus_w_valid   = 1'b0;
        bus_w_data    = '0;
        bus_w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) w_next = req_dirty ? WB_RD : RF_AR;
            end
            WB_RD: begin
                sram_addr = {w_victim, r_cnt[LW-1:0], 2'b00};
                sram_way  = r_way;
                if (r_cnt == CNT_END) w_next = WB_AW;
            end
            WB_AW: begin
                bus_wr_valid = 1'b1;
                bus_wr_addr  = {w_victim, {OFF{1'b0}}};
                if (bus_wr_ready) w_next = WB_W;
            end
            WB_W: begin
                bus_w_valid = 1'b1;
                bus_w_data  = r_buf[r_beat];
                bus_w_last  = &r_beat;
                if (bus_w_ready && &r_beat) w_next = WB_B;
            end
            WB_B: if (bus_b_valid) w_next = RF_AR;
            RF_AR: begin
                bus_rd_valid = 1'b1;
                bus_rd_addr  = {r_paddr[31:OFF], {OFF{1'b0}}};
                if (bus_rd_ready) w_next = RF_R;
            end
            RF_R: begin
                sram_addr    = {r_paddr[31:OFF], r_beat, 2'b00};
                sram_way     = r_way;
                sram_wdata   = bus_r_data;
                sram_data_we = {4{bus_r_valid}};
                if (bus_r_valid && (bus_r_last || &r_beat)) w_next = TAG_WR;
            end
            TAG_WR: begin
                sram_addr     = {r_paddr[31:OFF], {OFF{1'b0}}};
                sram_way      = r_way;
                sram_tag_we   = 1'b1;
                sram_tag_data = {r_paddr[31:32-TAG_W], 2'b10};
                w_next        = DONE;
            end
            DONE: begin
                resp_valid = !(r_drop || flush_i);
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_paddr    <= '0;
            r_way      <= '0;
            r_vtag     <= '0;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_buf      <= '{default: '0};
            r_drop     <= 1'b0;
            resp_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_paddr <= req_paddr[31:2];
                r_way   <= req_way;
                r_vtag  <= req_victim_tag;
                r_cnt   <= '0;
                r_beat  <= '0;
                r_drop  <= 1'b0;
            end
            // a flush never aborts the line transfer, it only hides the completion
            if (r_state != IDLE && flush_i) r_drop <= 1'b1;
            if (r_state == WB_RD) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt != '0) r_buf[w_cnt_m1[LW-1:0]] <= sram_rdata;
            end
            if (r_state == WB_W && bus_w_ready) r_beat <= r_beat + 1'b1;
            if (r_state == RF_R && bus_r_valid) begin
                if (r_beat == r_paddr[OFF-1:2]) resp_rdata <= bus_r_data;
                r_beat <= (bus_r_last || &r_beat) ? '0 : r_beat + 1'b1;
            end
        end
    end

`ifdef DCACHE_MISS_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_miss_cnt <= '0;
            perf_wb_cnt   <= '0;
        end else begin
            if (w_accept && !(&perf_miss_cnt)) perf_miss_cnt <= perf_miss_cnt + 1'b1;
            if (r_state == WB_B && bus_b_valid && !(&perf_wb_cnt)) perf_wb_cnt <= perf_wb_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb_dcache_miss_handler: directed bench for the dcache miss handler.
module tb_dcache_miss_handler;
    logic clk = 1'b0;
    logic rst, flush_i, req_valid, req_ready, req_dirty;
    logic [31:0] req_paddr, resp_rdata, sram_addr, sram_wdata, sram_rdata;
    logic [1:0] req_way, sram_way;
    logic [19:0] req_victim_tag;
    logic resp_valid, sram_tag_we;
    logic [3:0] sram_data_we;
    logic [21:0] sram_tag_data;
    logic bus_rd_valid, bus_rd_ready, bus_r_valid, bus_r_last;
    logic [31:0] bus_rd_addr, bus_r_data, bus_wr_addr, bus_w_data;
    logic bus_wr_valid, bus_wr_ready, bus_w_valid, bus_w_ready, bus_w_last, bus_b_valid;
`ifdef DCACHE_MISS_PERF_CNT_EN
    logic [31:0] perf_miss_cnt, perf_wb_cnt;
`endif

    always #5 clk = ~clk;

    dcache_miss_handler dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
        .req_way(req_way), .req_dirty(req_dirty), .req_victim_tag(req_victim_tag),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_addr(sram_addr), .sram_way(sram_way), .sram_data_we(sram_data_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_tag_we(sram_tag_we), .sram_tag_data(sram_tag_data),
        .bus_rd_valid(bus_rd_valid), .bus_rd_ready(bus_rd_ready), .bus_rd_addr(bus_rd_addr),
        .bus_r_valid(bus_r_valid), .bus_r_data(bus_r_data), .bus_r_last(bus_r_last),
        .bus_wr_valid(bus_wr_valid), .bus_wr_ready(bus_wr_ready), .bus_wr_addr(bus_wr_addr),
        .bus_w_valid(bus_w_valid), .bus_w_ready(bus_w_ready), .bus_w_data(bus_w_data),
        .bus_w_last(bus_w_last), .bus_b_valid(bus_b_valid)
`ifdef DCACHE_MISS_PERF_CNT_EN
        , .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
`endif
    );

    int n_chk = 0, n_err = 0;
    logic [31:0] wr_data [64], wr_addr [64], w_data [64];
    logic        w_last [64];
    int wr_n = 0, tag_n = 0, resp_n = 0, w_n = 0;
    bit wr_seen = 0;

    // SRAM returns 0x11 + word index; monitors log SRAM writes and bus write beats
    always @(posedge clk) begin
        sram_rdata <= 32'h11 + 32'(sram_addr[3:2]);
        if (sram_data_we == 4'hF) begin
            wr_data[wr_n] <= sram_wdata;
            wr_addr[wr_n] <= sram_addr;
            wr_n <= wr_n + 1;
        end
        if (sram_tag_we) tag_n <= tag_n + 1;
        if (resp_valid) resp_n <= resp_n + 1;
        if (bus_wr_valid || bus_w_valid) wr_seen <= 1'b1;
        if (bus_w_valid && bus_w_ready) begin
            w_data[w_n] <= bus_w_data;
            w_last[w_n] <= bus_w_last;
            w_n <= w_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input string tag, input bit wr);
        for (int k = 0; k < 50; k++) begin
            if ((wr ? bus_wr_valid : bus_rd_valid) === 1'b1) break;
            @(negedge clk);
        end
        chk(tag, {31'b0, wr ? bus_wr_valid : bus_rd_valid}, 1);
    endtask

    task automatic issue(input logic [31:0] pa, input logic [1:0] way, input logic dirty,
                         input logic [19:0] vtag, input bit hold);
        chk("req_ready_idle", {31'b0, req_ready}, 1);
        req_valid = 1'b1; req_paddr = pa; req_way = way; req_dirty = dirty; req_victim_tag = vtag;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        chk("req_ready_busy", {31'b0, req_ready}, 0);
    endtask

    task automatic writeback(input logic [31:0] exp_addr, input int aw_stall, input int w_stall, input int b_delay);
        int w0;
        w0 = w_n;
        wait_sig("wr_valid_wait", 1'b1);
        chk("wr_addr", bus_wr_addr, exp_addr);
        repeat (aw_stall) begin
            @(negedge clk);
            chk("aw_hold", {31'b0, bus_wr_valid}, 1);
        end
        bus_wr_ready = 1'b1;
        @(negedge clk);
        bus_wr_ready = 1'b0;
        chk("w_valid", {31'b0, bus_w_valid}, 1);
        repeat (w_stall) begin
            @(negedge clk);
            chk("w_data_stable", bus_w_data, 32'h11);
        end
        bus_w_ready = 1'b1;
        for (int k = 0; k < 20 && w_n < w0 + 4; k++) @(negedge clk);
        bus_w_ready = 1'b0;
        chk("w_beat_count", w_n - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("w_beat_data", w_data[w0+i], 32'h11 + i);
            chk("w_beat_last", {31'b0, w_last[w0+i]}, (i == 3) ? 1 : 0);
        end
        repeat (b_delay) begin
            chk("rd_before_b", {31'b0, bus_rd_valid}, 0);
            @(negedge clk);
        end
        bus_b_valid = 1'b1;
        @(negedge clk);
        bus_b_valid = 1'b0;
    endtask

    task automatic refill(input logic [31:0] line, input logic [31:0] base, input int flush_at,
                          input logic [31:0] exp_resp, input logic exp_rv);
        int w0, t0, r0;
        w0 = wr_n; t0 = tag_n; r0 = resp_n;
        wait_sig("rd_valid_wait", 1'b0);
        chk("rd_addr", bus_rd_addr, line);
        bus_rd_ready = 1'b1;
        @(negedge clk);
        bus_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_r_valid = 1'b1; bus_r_data = base + i; bus_r_last = (i == 3); flush_i = (i == flush_at);
            @(negedge clk);
        end
        bus_r_valid = 1'b0; bus_r_last = 1'b0; flush_i = 1'b0;
        chk("tag_we", {31'b0, sram_tag_we}, 1);
        chk("tag_data", {10'b0, sram_tag_data}, {10'b0, line[31:12], 2'b10});
        chk("tag_cycle_data_we", {28'b0, sram_data_we}, 0);
        @(negedge clk);
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
        chk("resp_rdata", resp_rdata, exp_resp);
        chk("ready_in_done", {31'b0, req_ready}, 0);
        @(negedge clk);
        chk("resp_pulses", resp_n - r0, {31'b0, exp_rv});
        chk("sram_writes", wr_n - w0, 4);
        chk("tag_writes", tag_n - t0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("sram_wdata", wr_data[w0+i], base + i);
            chk("sram_waddr", wr_addr[w0+i], line + 4 * i);
        end
        chk("req_ready_back", {31'b0, req_ready}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; req_valid = 1'b0; req_paddr = '0; req_way = '0; req_dirty = 1'b0;
        req_victim_tag = '0; bus_rd_ready = 1'b0; bus_r_valid = 1'b0; bus_r_data = '0; bus_r_last = 1'b0;
        bus_wr_ready = 1'b0; bus_w_ready = 1'b0; bus_b_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_valids", {26'b0, resp_valid, sram_tag_we, bus_rd_valid, bus_wr_valid, bus_w_valid, bus_w_last}, 0);
        chk("rst_data_we", {28'b0, sram_data_we}, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean miss
        issue(32'h0000_1238, 2'b01, 1'b0, 20'h0, 1'b0);
        refill(32'h0000_1230, 32'hA0, -1, 32'hA2, 1'b1);
        chk("clean_no_wr_bus", {31'b0, wr_seen}, 0);

        // 2: dirty miss, refill held until write response
        issue(32'h0000_2040, 2'b10, 1'b1, 20'h00005, 1'b0);
        chk("wbrd_addr0", sram_addr, 32'h0000_5040);
        chk("wbrd_way", {30'b0, sram_way}, 2);
        chk("wbrd_no_we", {28'b0, sram_data_we}, 0);
        writeback(32'h0000_5040, 0, 0, 3);
        refill(32'h0000_2040, 32'hB0, -1, 32'hB0, 1'b1);

        // 3: backpressure on write address and write data
        issue(32'h0000_3004, 2'b01, 1'b1, 20'h0000A, 1'b0);
        writeback(32'h0000_A000, 3, 3, 1);
        refill(32'h0000_3000, 32'hC0, -1, 32'hC1, 1'b1);

        // 4: flush at second refill beat
        issue(32'h0000_4008, 2'b01, 1'b0, 20'h0, 1'b0);
        refill(32'h0000_4000, 32'hD0, 1, 32'hD2, 1'b0);

        // 5: back-to-back with req_valid held
        issue(32'h0000_500C, 2'b10, 1'b0, 20'h0, 1'b1);
        refill(32'h0000_5000, 32'hE0, -1, 32'hE3, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_accepted", {31'b0, req_ready}, 0);
        chk("b2b_rd_valid", {31'b0, bus_rd_valid}, 1);
        refill(32'h0000_5000, 32'hF0, -1, 32'hF3, 1'b1);

        // 6: reset during WB_W
        issue(32'h0000_6000, 2'b01, 1'b1, 20'h00007, 1'b0);
        wait_sig("rst_wr_wait", 1'b1);
        bus_wr_ready = 1'b1;
        @(negedge clk);
        bus_wr_ready = 1'b0;
        chk("rst_in_wbw", {31'b0, bus_w_valid}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", {31'b0, req_ready}, 1);
        chk("midrst_valids", {26'b0, resp_valid, sram_tag_we, bus_rd_valid, bus_wr_valid, bus_w_valid, bus_w_last}, 0);
        chk("midrst_data_we", {28'b0, sram_data_we}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
